// File: rtl/aes_pkg.sv
// aes_pkg: shared types and helpers for the AES control sequencer.
//   opcode    : 3-bit instruction code sampled with start_i
//   seq_state : sequencer FSM states
//   nr_of     : number of cipher rounds for a key length in 32-bit words
//   op_legal  : 1 when a raw 3-bit code names an executable instruction
package aes_pkg;

  typedef enum logic [2:0] {
    NOOP            = 3'd0,
    AESENC          = 3'd1,
    AESENCLAST      = 3'd2,
    AESKEYGENASSIST = 3'd3,
    AESENCFULL      = 3'd4
  } opcode;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEY0  = 3'd1,
    SBOX  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } seq_state;

  function automatic int unsigned nr_of(input int unsigned nk);
    return nk + 32'd6;
  endfunction

  // Codes 5..7 are reserved and NOOP does no work, so all four are rejected.
  function automatic logic op_legal(input logic [2:0] op);
    logic legal_s;
    case (op)
      3'd1, 3'd2, 3'd3, 3'd4: legal_s = 1'b1;
      default:                legal_s = 1'b0;
    endcase
    return legal_s;
  endfunction

endpackage

// File: rtl/aes_rnd_counter.sv
// aes_rnd_counter: round index register for the AES sequencer.
//   clk, nrst : clock, asynchronous active-low reset
//   clr       : force count to 0 (highest priority)
//   ld        : load count with 1 (first real round)
//   inc       : advance count by one; saturates at NR so it never wraps
//   cnt       : current round index
//   term      : count equals NR (last round)
module aes_rnd_counter #(
  parameter int unsigned NR    = 10,
  parameter int unsigned RND_W = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             ld,
  input  logic             inc,
  output logic [RND_W-1:0] cnt,
  output logic             term
);

  logic [RND_W-1:0] cnt_r;
  logic             term_s;

  assign term_s = (cnt_r == RND_W'(NR));

  // Round index register: clear > load-one > saturating increment > hold.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_r <= {RND_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {RND_W{1'b0}};
    end else if (ld) begin
      cnt_r <= RND_W'(1);
    end else if (inc && !term_s) begin
      cnt_r <= cnt_r + RND_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign term = term_s;

endmodule

// File: rtl/aes_round_seq.sv
// aes_round_seq: control sequencer for the AES datapath (round logic,
// S-box, key_gen). Runs single-round AESENC/AESENCLAST, AESKEYGENASSIST
// and a complete NR-round AESENCFULL.
//   clk, nrst      : clock, asynchronous active-low reset
//   start_i        : request, taken only in IDLE with hold_i low
//   opcode_i       : aes_pkg::opcode, sampled with start_i
//   hold_i         : datapath stall, freezes sequencing and masks strobes
//   abort_i        : synchronous cancel back to IDLE
//   ready_o/busy_o : FSM in / not in IDLE
//   rnd_idx_o      : current round number 0..NR
//   zero_rnd_o, full_enc_o, final_rnd_o : round-type controls
//   key_sel_o, key_sub_o, gen_key_o, r_con_rst_o, next_rnd_o : key path
//   cipher_ready_o, key_ready_o : one-cycle done pulses
//   illegal_o      : registered pulse for a rejected opcode
module aes_round_seq
  import aes_pkg::*;
#(
  parameter int unsigned NK    = 4,
  parameter int unsigned RND_W = $clog2(NK + 7)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start_i,
  input  logic [2:0]       opcode_i,
  input  logic             hold_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic [RND_W-1:0] rnd_idx_o,
  output logic             zero_rnd_o,
  output logic             full_enc_o,
  output logic             final_rnd_o,
  output logic             key_sel_o,
  output logic             key_sub_o,
  output logic             gen_key_o,
  output logic             r_con_rst_o,
  output logic             next_rnd_o,
  output logic             cipher_ready_o,
  output logic             key_ready_o,
  output logic             illegal_o
);

  localparam int unsigned NR = nr_of(NK);

  if (!(NK == 32'd4 || NK == 32'd6 || NK == 32'd8)) begin : g_bad_nk
    $error("aes_round_seq: NK must be 4, 6 or 8");
  end

  seq_state         state_r, state_nxt_s;
  opcode            op_r, op_nxt_s;
  logic             illegal_r, illegal_nxt_s;
  logic             cnt_clr_s, cnt_ld_s, cnt_inc_s;
  logic [RND_W-1:0] rnd_cnt_s;
  logic             rnd_term_s;
  logic             stall_s;

  // A stall only matters once an operation is in flight.
  assign stall_s = hold_i && (state_r != IDLE);

  aes_rnd_counter #(
    .NR    (NR),
    .RND_W (RND_W)
  ) u_rnd_counter (
    .clk  (clk),
    .nrst (nrst),
    .clr  (cnt_clr_s),
    .ld   (cnt_ld_s),
    .inc  (cnt_inc_s),
    .cnt  (rnd_cnt_s),
    .term (rnd_term_s)
  );

  // State, latched opcode and illegal-opcode pulse registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r   <= IDLE;
      op_r      <= NOOP;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      op_r      <= op_nxt_s;
      illegal_r <= illegal_nxt_s;
    end
  end

  // Next-state, opcode latch and round-counter control.
  always_comb begin
    state_nxt_s   = state_r;
    op_nxt_s      = op_r;
    illegal_nxt_s = 1'b0;
    cnt_clr_s     = 1'b0;
    cnt_ld_s      = 1'b0;
    cnt_inc_s     = 1'b0;
    if (abort_i) begin
      // Abort outranks hold and start, including a start in IDLE.
      state_nxt_s = IDLE;
      op_nxt_s    = NOOP;
      cnt_clr_s   = 1'b1;
    end else if (stall_s) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i && !hold_i) begin
            if (op_legal(opcode_i)) begin
              op_nxt_s  = opcode'(opcode_i);
              cnt_clr_s = 1'b1;
              case (opcode_i)
                3'd3:    state_nxt_s = ROUND;
                3'd4:    state_nxt_s = KEY0;
                default: state_nxt_s = SBOX;
              endcase
            end else begin
              illegal_nxt_s = 1'b1;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        KEY0: begin
          cnt_ld_s    = 1'b1;
          state_nxt_s = SBOX;
        end
        SBOX: begin
          state_nxt_s = ROUND;
        end
        ROUND: begin
          if (op_r == AESENCFULL && !rnd_term_s) begin
            cnt_inc_s   = 1'b1;
            state_nxt_s = SBOX;
          end else begin
            state_nxt_s = DONE;
          end
        end
        DONE: begin
          op_nxt_s    = NOOP;
          state_nxt_s = IDLE;
        end
        default: begin
          op_nxt_s    = NOOP;
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Moore output decode from state, latched op and round index; single-fire
  // strobes are masked while stalled so each fires once per round.
  always_comb begin
    ready_o        = 1'b0;
    busy_o         = 1'b1;
    zero_rnd_o     = 1'b0;
    full_enc_o     = 1'b0;
    final_rnd_o    = 1'b0;
    key_sel_o      = 1'b0;
    key_sub_o      = 1'b0;
    gen_key_o      = 1'b0;
    r_con_rst_o    = 1'b0;
    next_rnd_o     = 1'b0;
    cipher_ready_o = 1'b0;
    key_ready_o    = 1'b0;
    case (state_r)
      IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
      end
      KEY0: begin
        zero_rnd_o  = 1'b1;
        r_con_rst_o = 1'b1;
      end
      SBOX: begin
        if (op_r == AESENCFULL) begin
          key_sub_o = 1'b1;
          gen_key_o = 1'b1;
        end else begin
          key_sub_o = 1'b0;
        end
      end
      ROUND: begin
        case (op_r)
          AESENC:          full_enc_o  = 1'b1;
          AESENCLAST:      final_rnd_o = 1'b1;
          AESKEYGENASSIST: begin
            key_sub_o = 1'b1;
            gen_key_o = 1'b1;
          end
          AESENCFULL: begin
            key_sel_o  = 1'b1;
            next_rnd_o = 1'b1;
            if (rnd_term_s) begin
              final_rnd_o = 1'b1;
            end else begin
              full_enc_o = 1'b1;
            end
          end
          default: full_enc_o = 1'b0;
        endcase
      end
      DONE: begin
        if (op_r == AESKEYGENASSIST) begin
          key_ready_o = 1'b1;
        end else begin
          cipher_ready_o = 1'b1;
        end
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
    if (stall_s) begin
      gen_key_o      = 1'b0;
      next_rnd_o     = 1'b0;
      r_con_rst_o    = 1'b0;
      cipher_ready_o = 1'b0;
      key_ready_o    = 1'b0;
    end else begin
      next_rnd_o = next_rnd_o;
    end
  end

  assign rnd_idx_o = rnd_cnt_s;
  assign illegal_o = illegal_r;

endmodule

// File: tb/tb_aes_round_seq.sv
module tb_aes_round_seq;
  import aes_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst = 1'b0;
  logic       start4 = 1'b0, start8 = 1'b0, hold = 1'b0, abort = 1'b0;
  logic [2:0] opc = 3'd0;

  logic       rdy4, bsy4, zr4, fe4, fr4, ks4, ku4, gk4, rc4, nr4, cr4, kr4, il4;
  logic [3:0] idx4;
  logic       rdy8, bsy8, zr8, fe8, fr8, ks8, ku8, gk8, rc8, nr8, cr8, kr8, il8;
  logic [3:0] idx8;

  aes_round_seq #(.NK(4)) u_dut4 (
    .clk(clk), .nrst(nrst), .start_i(start4), .opcode_i(opc), .hold_i(hold),
    .abort_i(abort), .ready_o(rdy4), .busy_o(bsy4), .rnd_idx_o(idx4),
    .zero_rnd_o(zr4), .full_enc_o(fe4), .final_rnd_o(fr4), .key_sel_o(ks4),
    .key_sub_o(ku4), .gen_key_o(gk4), .r_con_rst_o(rc4), .next_rnd_o(nr4),
    .cipher_ready_o(cr4), .key_ready_o(kr4), .illegal_o(il4)
  );

  aes_round_seq #(.NK(8)) u_dut8 (
    .clk(clk), .nrst(nrst), .start_i(start8), .opcode_i(opc), .hold_i(hold),
    .abort_i(abort), .ready_o(rdy8), .busy_o(bsy8), .rnd_idx_o(idx8),
    .zero_rnd_o(zr8), .full_enc_o(fe8), .final_rnd_o(fr8), .key_sel_o(ks8),
    .key_sub_o(ku8), .gen_key_o(gk8), .r_con_rst_o(rc8), .next_rnd_o(nr8),
    .cipher_ready_o(cr8), .key_ready_o(kr8), .illegal_o(il8)
  );

  // Selected-DUT view used by the cycle logger.
  bit         sel8 = 1'b0;
  logic       s_rdy, s_bsy, s_zr, s_fe, s_fr, s_ku, s_gk, s_rc, s_nr, s_cr, s_kr, s_il;
  logic [3:0] s_idx;
  always_comb begin
    s_rdy = sel8 ? rdy8 : rdy4;  s_bsy = sel8 ? bsy8 : bsy4;
    s_zr  = sel8 ? zr8  : zr4;   s_fe  = sel8 ? fe8  : fe4;
    s_fr  = sel8 ? fr8  : fr4;   s_ku  = sel8 ? ku8  : ku4;
    s_gk  = sel8 ? gk8  : gk4;   s_rc  = sel8 ? rc8  : rc4;
    s_nr  = sel8 ? nr8  : nr4;   s_cr  = sel8 ? cr8  : cr4;
    s_kr  = sel8 ? kr8  : kr4;   s_il  = sel8 ? il8  : il4;
    s_idx = sel8 ? idx8 : idx4;
  end

  int tests = 0;
  int fails = 0;

  // Per-run statistics and per-cycle logs (cycle 1 = first cycle after accept).
  int   done_cyc, done_cnt, cipher_cnt, key_cnt, next_cnt, gen_cnt, rcon_cnt;
  int   zero_cnt, full_cnt, final_cnt, final_bad, ksub_cnt, nr_exp;
  logic       ready_log [0:63];
  logic       busy_log  [0:63];
  logic       full_log  [0:63];
  logic       final_log [0:63];
  logic       ill_log   [0:63];
  logic [3:0] idx_log   [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one start and log `budget` cycles; hold/abort/extra starts follow the schedule.
  task automatic run_op(input logic [2:0] op, input bit use8, input int budget,
                        input int hold_from, input int hold_len, input int abort_at,
                        input bit keep_start);
    sel8 = use8;
    nr_exp = use8 ? 14 : 10;
    done_cyc = -1; done_cnt = 0; cipher_cnt = 0; key_cnt = 0; next_cnt = 0;
    gen_cnt = 0; rcon_cnt = 0; zero_cnt = 0; full_cnt = 0; final_cnt = 0;
    final_bad = 0; ksub_cnt = 0;
    @(posedge clk); #1;
    opc = op;
    if (use8) start8 = 1'b1; else start4 = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start4 = 1'b0; start8 = 1'b0;
      if (keep_start && c <= 3) begin
        opc = AESENCFULL;
        if (use8) start8 = 1'b1; else start4 = 1'b1;
      end
      hold  = (c >= hold_from) && (c < hold_from + hold_len);
      abort = (c == abort_at);
      #1;
      ready_log[c] = s_rdy; busy_log[c] = s_bsy; full_log[c] = s_fe;
      final_log[c] = s_fr;  ill_log[c]  = s_il;  idx_log[c]  = s_idx;
      if ((s_cr || s_kr) && done_cyc < 0) done_cyc = c;
      done_cnt   += int'(s_cr) + int'(s_kr);
      cipher_cnt += int'(s_cr);
      key_cnt    += int'(s_kr);
      next_cnt   += int'(s_nr);
      gen_cnt    += int'(s_gk);
      rcon_cnt   += int'(s_rc);
      zero_cnt   += int'(s_zr);
      full_cnt   += int'(s_fe);
      final_cnt  += int'(s_fr);
      ksub_cnt   += int'(s_ku);
      if (s_fr && s_idx != 4'(nr_exp) && (op == AESENCFULL)) final_bad++;
    end
    hold = 1'b0; abort = 1'b0; start4 = 1'b0; start8 = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ready", 32'(rdy4), 32'd1);
    chk("rst_busy", 32'(bsy4), 32'd0);
    chk("rst_idx", 32'(idx4), 32'd0);
    chk("rst_illegal", 32'(il4), 32'd0);
    chk("rst_cipher", 32'(cr4), 32'd0);
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // 1. AESENC single round
    run_op(AESENC, 1'b0, 5, 0, 0, 0, 1'b0);
    chk("enc_busy_c1", 32'(busy_log[1]), 32'd1);
    chk("enc_full_c2", 32'(full_log[2]), 32'd1);
    chk("enc_final_c2", 32'(final_log[2]), 32'd0);
    chk("enc_done_cyc", 32'(done_cyc), 32'd3);
    chk("enc_ready_c4", 32'(ready_log[4]), 32'd1);
    chk("enc_cipher_cnt", 32'(cipher_cnt), 32'd1);
    chk("enc_next_cnt", 32'(next_cnt), 32'd0);

    // 2a. AESENCFULL, NK=4
    run_op(AESENCFULL, 1'b0, 24, 0, 0, 0, 1'b0);
    chk("full4_rcon", 32'(rcon_cnt), 32'd1);
    chk("full4_zero", 32'(zero_cnt), 32'd1);
    chk("full4_next", 32'(next_cnt), 32'd10);
    chk("full4_gen", 32'(gen_cnt), 32'd10);
    chk("full4_fullenc", 32'(full_cnt), 32'd9);
    chk("full4_final", 32'(final_cnt), 32'd1);
    chk("full4_final_idx", 32'(final_bad), 32'd0);
    chk("full4_done_cyc", 32'(done_cyc), 32'd22);
    chk("full4_idx_c21", 32'(idx_log[21]), 32'd10);

    // 2b. AESENCFULL, NK=8
    run_op(AESENCFULL, 1'b1, 32, 0, 0, 0, 1'b0);
    chk("full8_next", 32'(next_cnt), 32'd14);
    chk("full8_final", 32'(final_cnt), 32'd1);
    chk("full8_final_idx", 32'(final_bad), 32'd0);
    chk("full8_done_cyc", 32'(done_cyc), 32'd30);
    chk("full8_cipher_cnt", 32'(cipher_cnt), 32'd1);

    // 3. AESKEYGENASSIST
    run_op(AESKEYGENASSIST, 1'b0, 4, 0, 0, 0, 1'b0);
    chk("kga_ksub", 32'(ksub_cnt), 32'd1);
    chk("kga_gen", 32'(gen_cnt), 32'd1);
    chk("kga_done_cyc", 32'(done_cyc), 32'd2);
    chk("kga_key_cnt", 32'(key_cnt), 32'd1);
    chk("kga_cipher_cnt", 32'(cipher_cnt), 32'd0);

    // 4. Hold for 3 cycles in ROUND of round 5 (cycle 11)
    run_op(AESENCFULL, 1'b0, 27, 11, 3, 0, 1'b0);
    chk("hold_idx_c12", 32'(idx_log[12]), 32'd5);
    chk("hold_idx_c13", 32'(idx_log[13]), 32'd5);
    chk("hold_full_c13", 32'(full_log[13]), 32'd1);
    chk("hold_next", 32'(next_cnt), 32'd10);
    chk("hold_gen", 32'(gen_cnt), 32'd10);
    chk("hold_done_cyc", 32'(done_cyc), 32'd25);

    // 5. Abort in SBOX of round 7 (cycle 14), then a normal AESENC
    run_op(AESENCFULL, 1'b0, 24, 0, 0, 14, 1'b0);
    chk("abort_idx_c14", 32'(idx_log[14]), 32'd7);
    chk("abort_ready_c15", 32'(ready_log[15]), 32'd1);
    chk("abort_idx_c15", 32'(idx_log[15]), 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_op(AESENC, 1'b0, 5, 0, 0, 0, 1'b0);
    chk("post_abort_done", 32'(done_cyc), 32'd3);

    // 6. Illegal opcodes and start while busy
    run_op(3'd0, 1'b0, 3, 0, 0, 0, 1'b0);
    chk("ill0_pulse", 32'(ill_log[1]), 32'd1);
    chk("ill0_clear", 32'(ill_log[2]), 32'd0);
    chk("ill0_idle", 32'(busy_log[1]), 32'd0);
    run_op(3'd6, 1'b0, 3, 0, 0, 0, 1'b0);
    chk("ill6_pulse", 32'(ill_log[1]), 32'd1);
    chk("ill6_no_done", 32'(done_cnt), 32'd0);
    run_op(AESENC, 1'b0, 6, 0, 0, 0, 1'b1);
    chk("busy_start_done", 32'(done_cyc), 32'd3);
    chk("busy_start_next", 32'(next_cnt), 32'd0);
    chk("busy_start_idle", 32'(busy_log[5]), 32'd0);

    // nrst mid-operation returns straight to reset values
    sel8 = 1'b0;
    @(posedge clk); #1;
    opc = AESENCFULL; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_idx", 32'(idx4), 32'd2);
    nrst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(rdy4), 32'd1);
    chk("mid_rst_idx", 32'(idx4), 32'd0);
    chk("mid_rst_busy", 32'(bsy4), 32'd0);
    #5 nrst = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
- Parametrised AES control sequencer for the AES datapath: aes_enc round logic, S-box, key_gen.
- Executes single-round AESENC/AESENCLAST and AESKEYGENASSIST, plus new AESENCFULL: a complete NR-round encryption for AES-128/192/256.
- Adds round counting, start/ready handshake, hold (datapath stall), synchronous abort and illegal-opcode flagging.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4/6/8, any other value is an elaboration error. NR = NK+6.
- RND_W, $clog2(NK+7), round index width (4 for all legal NK).

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- start_i  in  1  request; accepted only when ready_o=1 and hold_i=0
- opcode_i  in  3  aes_pkg::opcode, sampled with start_i
- hold_i  in  1  datapath stall; freezes sequencing
- abort_i  in  1  synchronous cancel
- ready_o  in/out: out  1  FSM in IDLE
- busy_o  out  1  FSM not in IDLE
- rnd_idx_o  out  RND_W  current round number, 0..NR
- zero_rnd_o  out  1  round 0, AddRoundKey only
- full_enc_o  out  1  middle round, MixColumns applied
- final_rnd_o  out  1  last round, MixColumns skipped
- key_sel_o  out  1  0 = external key, 1 = generated round key
- key_sub_o  out  1  S-box serves key path
- gen_key_o  out  1  key_gen expansion strobe
- r_con_rst_o  out  1  reset Rcon to 0x01
- next_rnd_o  out  1  advance Rcon
- cipher_ready_o  out  1  one-cycle done pulse, encrypt ops
- key_ready_o  out  1  one-cycle done pulse, AESKEYGENASSIST
- illegal_o  out  1  registered one-cycle pulse on a rejected opcode

Behaviour:
- Reset: state IDLE, op latch NOOP, rnd_cnt 0, illegal_o 0. All outputs 0 except ready_o=1.
- States: IDLE, KEY0, SBOX, ROUND, DONE. All outputs are decoded from state, latched op and rnd_cnt (Moore), except illegal_o.
- IDLE: start_i & legal op latches the op and clears rnd_cnt.
  - AESENC/AESENCLAST -> SBOX.
  - AESKEYGENASSIST -> ROUND.
  - AESENCFULL -> KEY0.
  - NOOP/reserved -> stay in IDLE, illegal_o=1 next cycle.
- start_i outside IDLE is ignored; no queueing.
- KEY0 (full only): zero_rnd_o=1, key_sel_o=0, r_con_rst_o=1. rnd_cnt <= 1, -> SBOX.
- SBOX:
  - full: key_sub_o=1, gen_key_o=1.
  - single: all strobes 0.
  - -> ROUND.
- ROUND:
  - AESENC: full_enc_o=1, key_sel_o=0, -> DONE.
  - AESENCLAST: final_rnd_o=1, key_sel_o=0, -> DONE.
  - AESKEYGENASSIST: key_sub_o=1, gen_key_o=1, -> DONE.
  - AESENCFULL: key_sel_o=1, next_rnd_o=1; full_enc_o=1 if rnd_cnt<NR, else final_rnd_o=1.
    - rnd_cnt<NR: rnd_cnt++, -> SBOX.
    - rnd_cnt==NR: -> DONE.
- DONE: key_ready_o=1 for AESKEYGENASSIST, otherwise cipher_ready_o=1. Clear op, -> IDLE.
- rnd_idx_o = rnd_cnt; it never exceeds NR and never wraps.
- Latency, in cycles from the accept edge to the done pulse:
  - AESENC/AESENCLAST: 3.
  - AESKEYGENASSIST: 2.
  - AESENCFULL: 2*NR+2, i.e. 22/26/30 for NK=4/6/8.
- hold_i=1 in a non-IDLE state:
  - state and rnd_cnt are frozen.
  - gen_key_o, next_rnd_o, r_con_rst_o, cipher_ready_o, key_ready_o are forced 0; other outputs hold their values.
  - Strobes reassert once hold_i drops, so each strobe fires exactly once per round.
- abort_i=1: next state IDLE, rnd_cnt 0, op NOOP.
  - Priority over hold_i and start_i; an abort while in IDLE discards a simultaneous start.
  - The current cycle's outputs are not masked, so an abort in DONE still yields that cycle's pulse.
  - No done pulse is issued for an aborted op.
- nrst mid-operation: immediate return to the reset values listed above.

Decomposition:
- aes_pkg holds:
  - opcode enum, 3 bits: NOOP=0, AESENC=1, AESENCLAST=2, AESKEYGENASSIST=3, AESENCFULL=4; 5-7 reserved.
  - seq_state enum.
  - Function nr_of(NK).
- Optional sub-module aes_rnd_counter: load/clear/increment/hold with a terminal flag at NR.

Test Plan:
1. NK=4, AESENC start in IDLE -> SBOX, ROUND (full_enc_o=1, final_rnd_o=0), cipher_ready_o pulse at cycle 3, ready_o=1 at cycle 4.
2. NK=4, AESENCFULL -> KEY0 with r_con_rst_o=1; 10 SBOX/ROUND pairs; next_rnd_o counts exactly 10; final_rnd_o only at rnd_idx_o=10; cipher_ready_o at cycle 22. Repeat with NK=8: cycle 30, 14 rounds.
3. AESKEYGENASSIST -> key_sub_o=1 and gen_key_o=1 for one cycle, key_ready_o at cycle 2, cipher_ready_o never asserts.
4. AESENCFULL with hold_i high for 3 cycles during ROUND of round 5 -> rnd_idx_o stays 5, next_rnd_o total still 10, done delayed to cycle 25.
5. abort_i during SBOX of round 7 -> IDLE next cycle, rnd_idx_o=0, no done pulse; a new AESENC then completes normally.
6. start_i with opcode 0 or 6 -> illegal_o pulse, state stays IDLE; start_i while busy -> ignored, first op's latency unchanged.
